// File: rtl/ram_arbiter_2_pkg.sv
// Shared definitions for the two-requester RAM arbiter: width defaults,
// FSM state encodings and address-region codes.
package ram_arbiter_2_pkg;

    // Default widths: requester data/address width and RAM address width
    localparam int DW_DEFAULT = 9;
    localparam int AW_DEFAULT = 7;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Address region codes, decoded from the top two address bits
    localparam logic [1:0] REGION_RAM      = 2'b00;
    localparam logic [1:0] REGION_LED      = 2'b01;
    localparam logic [1:0] REGION_UNMAPPED = 2'b10;

    // Map the two most significant address bits onto a region code
    function automatic logic [1:0] decode_region(input logic [1:0] top_bits);
        logic [1:0] region;
        case (top_bits)
            2'b00:   region = REGION_RAM;
            2'b01:   region = REGION_LED;
            default: region = REGION_UNMAPPED;
        endcase
        return region;
    endfunction

endpackage

// File: rtl/ram_arbiter_2_if.sv
// Bus bundle between the two requesters, the single-port RAM and the arbiter.
// The master side is the requesters plus the RAM; the slave side is the arbiter.
interface ram_arbiter_2_if
    import ram_arbiter_2_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
);
    logic          req0;
    logic          req1;
    logic [DW-1:0] addr0;
    logic [DW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          we0;
    logic          we1;
    logic          gnt0;
    logic          gnt1;
    logic          rvalid0;
    logic          rvalid1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wren;
    logic [DW-1:0] ram_q;

    modport master (
        output req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, ram_q,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_data, ram_wren
    );

    modport slave (
        input  req0, req1, addr0, addr1, wdata0, wdata1, we0, we1, ram_q,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_addr, ram_data, ram_wren
    );

endinterface

// File: rtl/regn.sv
// Generic W-bit register with synchronous active-low reset and load enable.
module regn #(
    parameter int W = 9
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear on reset, otherwise load d whenever en is high
    always_ff @(posedge Clock) begin
        if (!Resetn)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/ram_arbiter_2.sv
// Round-robin arbiter sharing one single-port RAM and a memory-mapped LED
// register between a processor (requester 0) and a loader (requester 1).
// Each access runs IDLE -> ACCESS -> RESP, so at most one access per 3 cycles.
module ram_arbiter_2
    import ram_arbiter_2_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input  logic          Clock,
    input  logic          Resetn,
    ram_arbiter_2_if.slave bus,
    output logic [DW-1:0] LEDs
);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic          winner;
    logic          last_served;
    logic          pick;
    logic          any_req;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          we_q;
    logic [1:0]    region;
    logic          in_access;
    logic          in_resp;
    logic          led_en;

    assign any_req   = bus.req0 || bus.req1;
    assign in_access = (state == ST_ACCESS);
    assign in_resp   = (state == ST_RESP);
    assign region    = decode_region(addr_q[DW-1:DW-2]);

    // Choose the requester to serve: on a tie, the one not served last
    always_comb begin
        pick = 1'b0;
        if (bus.req0 && bus.req1)
            pick = ~last_served;
        else if (bus.req1)
            pick = 1'b1;
    end

    // Next-state logic: any request starts an access, which always ends in RESP
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (any_req) state_next = ST_ACCESS;
            ST_ACCESS: state_next = ST_RESP;
            default:   state_next = ST_IDLE;
        endcase
    end

    // State register and capture of the winning request in IDLE
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state       <= ST_IDLE;
            last_served <= 1'b1;
            winner      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && any_req) begin
                winner      <= pick;
                last_served <= pick;
                addr_q      <= pick ? bus.addr1  : bus.addr0;
                wdata_q     <= pick ? bus.wdata1 : bus.wdata0;
                we_q        <= pick ? bus.we1    : bus.we0;
            end
        end
    end

    // RAM port: address and write data come straight from the latched request
    assign bus.ram_addr = addr_q[AW-1:0];
    assign bus.ram_data = wdata_q;
    assign bus.ram_wren = in_access && we_q && (region == REGION_RAM);

    // Grant and read-valid pulses for the current winner
    assign bus.gnt0    = in_access && !winner;
    assign bus.gnt1    = in_access &&  winner;
    assign bus.rvalid0 = in_resp && !we_q && !winner;
    assign bus.rvalid1 = in_resp && !we_q &&  winner;

    // Read data mux: zero except during a read response
    always_comb begin
        bus.rdata = '0;
        if (in_resp && !we_q) begin
            case (region)
                REGION_RAM: bus.rdata = bus.ram_q;
                REGION_LED: bus.rdata = LEDs;
                default:    bus.rdata = '0;
            endcase
        end
    end

    assign led_en = in_access && we_q && (region == REGION_LED);

    regn #(
        .W (DW)
    ) u_led_reg (
        .Clock  (Clock),
        .Resetn (Resetn),
        .en     (led_en),
        .d      (wdata_q),
        .q      (LEDs)
    );

endmodule

// File: tb/tb_ram_arbiter_2.sv
// Directed testbench for ram_arbiter_2 with a behavioural single-port RAM
// (registered address, unregistered q).
module tb_ram_arbiter_2;

    localparam int DW = 9;
    localparam int AW = 7;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic [DW-1:0] LEDs;
    int            total = 0;
    int            bad = 0;

    ram_arbiter_2_if #(.DW(DW), .AW(AW)) bus ();

    ram_arbiter_2 #(.DW(DW), .AW(AW)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus),
        .LEDs   (LEDs)
    );

    // Free-running clock
    always #5 Clock = ~Clock;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] ram_addr_q;

    // RAM model: write on wren, register the address for the read path
    always @(posedge Clock) begin
        if (bus.ram_wren)
            mem[bus.ram_addr] <= bus.ram_data;
        ram_addr_q <= bus.ram_addr;
    end

    assign bus.ram_q = mem[ram_addr_q];

    // Present a request on a negedge and wait (bounded) for its grant;
    // waited = cycles to grant, or -1 if it never came
    task automatic issue(input int who, input logic [DW-1:0] a, input logic [DW-1:0] d,
                         input logic w, output int waited);
        logic got;
        if (who == 0) begin
            bus.req0 = 1'b1; bus.addr0 = a; bus.wdata0 = d; bus.we0 = w;
        end else begin
            bus.req1 = 1'b1; bus.addr1 = a; bus.wdata1 = d; bus.we1 = w;
        end
        waited = 0;
        got = 1'b0;
        while (!got && waited < 5) begin
            @(negedge Clock);
            waited++;
            got = (who == 0) ? bus.gnt0 : bus.gnt1;
        end
        if (!got) waited = -1;
    endtask

    // Drop all requests once granted and advance to the RESP cycle
    task automatic release_req();
        bus.req0 = 1'b0; bus.we0 = 1'b0;
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        repeat (2) @(negedge Clock);
        total++; if (bus.gnt0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt0: got %b expected 0", bus.gnt0); end
        total++; if (bus.gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_gnt1: got %b expected 0", bus.gnt1); end
        total++; if (bus.rvalid0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid0: got %b expected 0", bus.rvalid0); end
        total++; if (bus.rvalid1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid1: got %b expected 0", bus.rvalid1); end
        total++; if (bus.ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL reset_wren: got %b expected 0", bus.ram_wren); end
        total++; if (LEDs !== 9'h000) begin bad++; $display("[TB] FAIL reset_leds: got %h expected 000", LEDs); end
        total++; if (bus.rdata !== 9'h000) begin bad++; $display("[TB] FAIL reset_rdata: got %h expected 000", bus.rdata); end
        Resetn = 1'b1;
    endtask

    task automatic test_write();
        int w;
        issue(0, 9'h003, 9'h005, 1'b1, w);
        total++; if (w !== 1) begin bad++; $display("[TB] FAIL wr_latency: got %0d expected 1", w); end
        total++; if (bus.gnt0 !== 1'b1) begin bad++; $display("[TB] FAIL wr_gnt0: got %b expected 1", bus.gnt0); end
        total++; if (bus.gnt1 !== 1'b0) begin bad++; $display("[TB] FAIL wr_gnt1: got %b expected 0", bus.gnt1); end
        total++; if (bus.ram_wren !== 1'b1) begin bad++; $display("[TB] FAIL wr_wren: got %b expected 1", bus.ram_wren); end
        total++; if (bus.ram_addr !== 7'h03) begin bad++; $display("[TB] FAIL wr_addr: got %h expected 03", bus.ram_addr); end
        total++; if (bus.ram_data !== 9'h005) begin bad++; $display("[TB] FAIL wr_data: got %h expected 005", bus.ram_data); end
        release_req();
        total++; if (bus.rvalid0 !== 1'b0) begin bad++; $display("[TB] FAIL wr_no_rvalid: got %b expected 0", bus.rvalid0); end
        total++; if (bus.ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL wr_wren_resp: got %b expected 0", bus.ram_wren); end
        total++; if (bus.gnt0 !== 1'b0) begin bad++; $display("[TB] FAIL wr_gnt_once: got %b expected 0", bus.gnt0); end
        @(negedge Clock);
    endtask

    task automatic test_read();
        int w;
        issue(0, 9'h003, 9'h000, 1'b0, w);
        total++; if (w !== 1) begin bad++; $display("[TB] FAIL rd_latency: got %0d expected 1", w); end
        total++; if (bus.ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL rd_wren: got %b expected 0", bus.ram_wren); end
        release_req();
        total++; if (bus.rvalid0 !== 1'b1) begin bad++; $display("[TB] FAIL rd_rvalid0: got %b expected 1", bus.rvalid0); end
        total++; if (bus.rvalid1 !== 1'b0) begin bad++; $display("[TB] FAIL rd_rvalid1: got %b expected 0", bus.rvalid1); end
        total++; if (bus.rdata !== 9'h005) begin bad++; $display("[TB] FAIL rd_data: got %h expected 005", bus.rdata); end
        @(negedge Clock);
        total++; if (bus.rvalid0 !== 1'b0) begin bad++; $display("[TB] FAIL rd_rvalid_once: got %b expected 0", bus.rvalid0); end
    endtask

    task automatic test_round_robin();
        logic exp0, exp1;
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        bus.req0 = 1'b1; bus.addr0 = 9'h003; bus.we0 = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 9'h003; bus.we1 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clock);
            exp0 = (k % 3 == 0) && ((k / 3) % 2 == 0);
            exp1 = (k % 3 == 0) && ((k / 3) % 2 == 1);
            total++; if (bus.gnt0 !== exp0) begin bad++; $display("[TB] FAIL rr_gnt0[%0d]: got %b expected %b", k, bus.gnt0, exp0); end
            total++; if (bus.gnt1 !== exp1) begin bad++; $display("[TB] FAIL rr_gnt1[%0d]: got %b expected %b", k, bus.gnt1, exp1); end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(negedge Clock);
    endtask

    task automatic test_led();
        int w;
        issue(1, 9'h080, 9'h1AB, 1'b1, w);
        total++; if (w !== 1) begin bad++; $display("[TB] FAIL led_wr_latency: got %0d expected 1", w); end
        total++; if (bus.ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL led_wr_wren: got %b expected 0", bus.ram_wren); end
        release_req();
        total++; if (LEDs !== 9'h1AB) begin bad++; $display("[TB] FAIL led_value: got %h expected 1ab", LEDs); end
        total++; if (bus.rvalid1 !== 1'b0) begin bad++; $display("[TB] FAIL led_wr_rvalid: got %b expected 0", bus.rvalid1); end
        @(negedge Clock);
        issue(1, 9'h080, 9'h000, 1'b0, w);
        release_req();
        total++; if (bus.rvalid1 !== 1'b1) begin bad++; $display("[TB] FAIL led_rd_rvalid: got %b expected 1", bus.rvalid1); end
        total++; if (bus.rdata !== 9'h1AB) begin bad++; $display("[TB] FAIL led_rd_data: got %h expected 1ab", bus.rdata); end
        @(negedge Clock);
        issue(1, 9'h100, 9'h000, 1'b0, w);
        release_req();
        total++; if (bus.rvalid1 !== 1'b1) begin bad++; $display("[TB] FAIL unmapped_rvalid: got %b expected 1", bus.rvalid1); end
        total++; if (bus.rdata !== 9'h000) begin bad++; $display("[TB] FAIL unmapped_data: got %h expected 000", bus.rdata); end
        @(negedge Clock);
    endtask

    task automatic test_reset_abort();
        int w;
        issue(0, 9'h003, 9'h000, 1'b0, w);
        total++; if (w !== 1) begin bad++; $display("[TB] FAIL abort_latency: got %0d expected 1", w); end
        bus.req0 = 1'b0;
        Resetn = 1'b0;
        @(negedge Clock);
        total++; if (bus.rvalid0 !== 1'b0) begin bad++; $display("[TB] FAIL abort_rvalid: got %b expected 0", bus.rvalid0); end
        total++; if (bus.gnt0 !== 1'b0) begin bad++; $display("[TB] FAIL abort_gnt: got %b expected 0", bus.gnt0); end
        total++; if (LEDs !== 9'h000) begin bad++; $display("[TB] FAIL abort_leds: got %h expected 000", LEDs); end
        Resetn = 1'b1;
        @(negedge Clock);
        total++; if (bus.rvalid0 !== 1'b0) begin bad++; $display("[TB] FAIL abort_rvalid_late: got %b expected 0", bus.rvalid0); end
        total++; if (bus.gnt0 !== 1'b0) begin bad++; $display("[TB] FAIL abort_gnt_late: got %b expected 0", bus.gnt0); end
    endtask

    task automatic test_wrap();
        int w;
        issue(0, 9'h07F, 9'h011, 1'b1, w);
        total++; if (bus.ram_addr !== 7'h7F) begin bad++; $display("[TB] FAIL wrap_addr_7f: got %h expected 7f", bus.ram_addr); end
        release_req(); @(negedge Clock);
        issue(0, 9'h000, 9'h022, 1'b1, w);
        total++; if (bus.ram_addr !== 7'h00) begin bad++; $display("[TB] FAIL wrap_addr_00: got %h expected 00", bus.ram_addr); end
        release_req(); @(negedge Clock);
        issue(0, 9'h0FF, 9'h0AA, 1'b1, w);
        total++; if (bus.ram_wren !== 1'b0) begin bad++; $display("[TB] FAIL wrap_0ff_wren: got %b expected 0", bus.ram_wren); end
        release_req();
        total++; if (LEDs !== 9'h0AA) begin bad++; $display("[TB] FAIL wrap_0ff_leds: got %h expected 0aa", LEDs); end
        @(negedge Clock);
        issue(0, 9'h07F, 9'h000, 1'b0, w);
        release_req();
        total++; if (bus.rdata !== 9'h011) begin bad++; $display("[TB] FAIL wrap_rd_7f: got %h expected 011", bus.rdata); end
        @(negedge Clock);
        issue(0, 9'h000, 9'h000, 1'b0, w);
        release_req();
        total++; if (bus.rdata !== 9'h022) begin bad++; $display("[TB] FAIL wrap_rd_00: got %h expected 022", bus.rdata); end
        @(negedge Clock);
        issue(0, 9'h0FF, 9'h000, 1'b0, w);
        release_req();
        total++; if (bus.rdata !== 9'h0AA) begin bad++; $display("[TB] FAIL wrap_rd_0ff: got %h expected 0aa", bus.rdata); end
        @(negedge Clock);
    endtask

    // Run every scenario in order, then report
    initial begin
        Resetn = 1'b0;
        bus.req0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0; bus.we0 = 1'b0;
        bus.req1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.we1 = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_led();
        test_reset_abort();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_2.md
RAM_ARBITER_2 -- requirements
Module: ram_arbiter_2

Interface
REQ-001 Parameter DW, default 9: data and address width of each requester port.
REQ-002 Parameter AW, default 7: RAM address width; the RAM holds 2^AW words.
REQ-003 Clock  in  1  sole clock; all state updates on the rising edge.
REQ-004 Resetn  in  1  synchronous, active-low reset.
REQ-005 req0, req1  in  1 each  access request from requester 0 (processor) and requester 1 (loader).
REQ-006 addr0, addr1  in  DW each  access address.
REQ-007 wdata0, wdata1  in  DW each  write data.
REQ-008 we0, we1  in  1 each  1 = write, 0 = read.
REQ-009 gnt0, gnt1  out  1 each  one-cycle grant pulse.
REQ-010 rvalid0, rvalid1  out  1 each  one-cycle read-data-valid pulse.
REQ-011 rdata  out  DW  read data shared by both requesters; valid only when an rvalid is high.
REQ-012 ram_addr  out  AW; ram_data  out  DW; ram_wren  out  1; ram_q  in  DW  single-port RAM interface (registered address, unregistered q).
REQ-013 LEDs  out  DW  memory-mapped LED register.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-015 In IDLE with any req high, the block SHALL latch the winner index, addr, wdata and we, and go to ACCESS; with no req, it stays in IDLE.
REQ-016 Arbitration SHALL be round-robin: with both req high, grant the requester not served last; with a single req high, grant that requester.
REQ-017 In ACCESS, the block SHALL assert gnt of the winner for exactly one cycle and drive ram_addr with latched addr[AW-1:0] and ram_data with latched wdata; it then goes to RESP.
REQ-018 Address decode on latched addr[DW-1:DW-2]: 00 = RAM; 01 = LED register; 1x = unmapped.
REQ-019 ram_wren SHALL be high only in ACCESS, for a RAM-region write; it is low in all other cases.
REQ-020 An LED-region write SHALL load LEDs at the edge ending ACCESS; an unmapped write SHALL have no effect.
REQ-021 In RESP, for a read, the block SHALL pulse the winner's rvalid, with rdata = ram_q (RAM region), LEDs (LED region) or 0 (unmapped); it then returns to IDLE.
REQ-022 A write SHALL produce no rvalid pulse, and the FSM still passes through RESP.
REQ-023 Latency: req sampled in IDLE at cycle t, gnt at t+1, rvalid at t+2, next arbitration at t+3; peak throughput is one access per 3 cycles.
REQ-024 Each requester SHALL hold req/addr/wdata/we stable until it sees gnt; a req still high in the IDLE cycle following RESP counts as a new request.
REQ-025 A requester that drops req before it is granted SHALL lose its request; no access is performed for it.
REQ-026 Address bits above AW-1 in the RAM region SHALL be ignored; RAM addresses wrap modulo 2^AW.

Reset
REQ-027 Resetn low at an edge SHALL force IDLE, gnt0/1 = 0, rvalid0/1 = 0, ram_wren = 0, LEDs = 0, rdata = 0, and the last-served pointer = requester 1 (so requester 0 wins the first tie).
REQ-028 Reset in ACCESS or RESP SHALL abort the access with no gnt or rvalid pulse afterward; a RAM write whose ACCESS cycle coincides with the reset edge SHALL still complete.

Structure
REQ-029 A shared package SHALL hold the state encodings, the region codes (RAM, LED, unmapped) and the DW/AW defaults.
REQ-030 The LED register SHALL be an instance of the codebase register module regn (width DW, enable = LED-region write in ACCESS).

Verification
REQ-031 After reset: LEDs = 0 and all pulse outputs are 0; req0 write 0x005 to addr 0x003 -> gnt0 at t+1, ram_wren=1, ram_addr=3, ram_data=0x005; no rvalid0.
REQ-032 req0 read addr 0x003 after that write -> gnt0 at t+1, rvalid0 at t+2 with rdata = 0x005.
REQ-033 req0 and req1 high together from reset -> grant order 0,1,0,1 over four accesses, each 3 cycles apart.
REQ-034 req1 write 0x1AB to addr 0x080 -> LEDs = 0x1AB in RESP, ram_wren stays 0; a read of 0x080 returns 0x1AB; a read of 0x100 returns 0.
REQ-035 Resetn low in the ACCESS cycle of a read -> IDLE next cycle, no rvalid pulse, LEDs = 0.
REQ-036 req0 read of addr 0x07F then 0x000 -> correct data at each address with no aliasing; addr 0x07F+0x80 (0x0FF) hits the LED region, not the RAM.
